// File: rtl/chan_select_seq.sv
// rtl/chan_select_seq.sv - N-channel registered selector with manual load and round-robin scan modes
module chan_select_seq #(
    parameter int              NUM_CH      = 3,
    parameter int              WIDTH       = 4,
    parameter int              SEL_W       = 2,
    parameter int              DWELL       = 4,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] din,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    load,
    output logic [WIDTH-1:0]        y,
    output logic                    y_valid,
    output logic [SEL_W-1:0]        cur_ch,
    output logic                    sel_err,
    output logic                    adv
);

    localparam int              DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] cur_ch_q, cur_ch_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic             err_sel_q, err_sel_d;
    logic             sel_err_q, sel_err_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic             adv_q, adv_d;

    logic             cur_en;
    logic [WIDTH-1:0] cur_data;
    logic             sel_ok;
    logic             any_en;
    logic             hi_found;
    logic [SEL_W-1:0] hi_ch;
    logic [SEL_W-1:0] lo_ch;
    logic [SEL_W-1:0] next_ch;

    always_comb begin
        cur_en   = 1'b0;
        cur_data = DEFAULT_VAL;
        sel_ok   = 1'b0;
        any_en   = 1'b0;
        hi_found = 1'b0;
        hi_ch    = cur_ch_q;
        lo_ch    = cur_ch_q;
        // Descending walk so the lowest matching index is the one that sticks.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (cur_ch_q == SEL_W'(k)) begin
                cur_en   = ch_en[k];
                cur_data = din[k*WIDTH +: WIDTH];
            end
            if (sel == SEL_W'(k)) begin
                sel_ok = ch_en[k];
            end
            if (ch_en[k]) begin
                any_en = 1'b1;
                lo_ch  = SEL_W'(k);
                if (SEL_W'(k) > cur_ch_q) begin
                    hi_found = 1'b1;
                    hi_ch    = SEL_W'(k);
                end
            end
        end
        // Wrap to the lowest enabled channel, which may be cur_ch itself.
        next_ch = hi_found ? hi_ch : lo_ch;
    end

    always_comb begin
        state_d   = mode ? SCAN : MANUAL;
        cur_ch_d  = cur_ch_q;
        dwell_d   = dwell_q;
        err_sel_d = err_sel_q;
        sel_err_d = sel_err_q;
        adv_d     = 1'b0;
        y_valid_d = cur_en && !err_sel_q;
        y_d       = y_valid_d ? cur_data : DEFAULT_VAL;

        case (state_q)
            MANUAL: begin
                if (mode) begin
                    dwell_d   = '0;
                    err_sel_d = 1'b0;
                end else if (load) begin
                    if (sel_ok) begin
                        cur_ch_d  = sel;
                        sel_err_d = 1'b0;
                        err_sel_d = 1'b0;
                    end else begin
                        sel_err_d = 1'b1;
                        err_sel_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (!mode) begin
                    dwell_d = '0;
                end else if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (any_en) begin
                        cur_ch_d = next_ch;
                        adv_d    = 1'b1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: state_d = MANUAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MANUAL;
            cur_ch_q  <= '0;
            dwell_q   <= '0;
            err_sel_q <= 1'b0;
            sel_err_q <= 1'b0;
            y_q       <= DEFAULT_VAL;
            y_valid_q <= 1'b0;
            adv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_ch_q  <= cur_ch_d;
            dwell_q   <= dwell_d;
            err_sel_q <= err_sel_d;
            sel_err_q <= sel_err_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            adv_q     <= adv_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign cur_ch  = cur_ch_q;
    assign sel_err = sel_err_q;
    assign adv     = adv_q;

endmodule

// File: tb/tb_chan_select_seq.sv
// tb/tb_chan_select_seq.sv - directed bench for chan_select_seq
module tb_chan_select_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] din;
    logic [2:0]  ch_en;
    logic        mode;
    logic [1:0]  sel;
    logic        load;
    logic [3:0]  y;
    logic        y_valid;
    logic [1:0]  cur_ch;
    logic        sel_err;
    logic        adv;

    int checks   = 0;
    int failures = 0;

    chan_select_seq #(
        .NUM_CH(3), .WIDTH(4), .SEL_W(2), .DWELL(4), .DEFAULT_VAL(4'd0)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .ch_en(ch_en), .mode(mode),
        .sel(sel), .load(load), .y(y), .y_valid(y_valid), .cur_ch(cur_ch),
        .sel_err(sel_err), .adv(adv)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; din = 12'h321; ch_en = 3'b111; mode = 1'b0; sel = 2'd0; load = 1'b0;
        tick(); tick();
        checks++;
        if (y !== 4'd0 || y_valid !== 1'b0 || cur_ch !== 2'd0 || sel_err !== 1'b0 || adv !== 1'b0) begin
            failures++;
            $display("FAIL reset: y=%0d v=%0b ch=%0d err=%0b adv=%0b, want 0 0 0 0 0", y, y_valid, cur_ch, sel_err, adv);
        end
        rst = 1'b0;
    endtask

    task automatic test_manual();
        logic [1:0] sels [3];
        logic [3:0] exp_y [3];
        sels[0] = 2'd1; sels[1] = 2'd2; sels[2] = 2'd0;
        exp_y[0] = 4'd2; exp_y[1] = 4'd3; exp_y[2] = 4'd1;
        for (int i = 0; i < 3; i++) begin
            sel = sels[i]; load = 1'b1;
            tick();
            load = 1'b0;
            checks++;
            if (cur_ch !== sels[i] || sel_err !== 1'b0) begin
                failures++;
                $display("FAIL manual_load%0d: ch=%0d err=%0b, want %0d 0", i, cur_ch, sel_err, sels[i]);
            end
            tick();
            checks++;
            if (y !== exp_y[i] || y_valid !== 1'b1) begin
                failures++;
                $display("FAIL manual_y%0d: y=%0d v=%0b, want %0d 1", i, y, y_valid, exp_y[i]);
            end
        end
    endtask

    task automatic test_invalid();
        sel = 2'd3; load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (sel_err !== 1'b1 || cur_ch !== 2'd0) begin
            failures++;
            $display("FAIL invalid_err: err=%0b ch=%0d, want 1 0", sel_err, cur_ch);
        end
        tick();
        checks++;
        if (y !== 4'd0 || y_valid !== 1'b0) begin
            failures++;
            $display("FAIL invalid_y: y=%0d v=%0b, want 0 0", y, y_valid);
        end
        sel = 2'd0; load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (sel_err !== 1'b0) begin
            failures++;
            $display("FAIL invalid_clear: err=%0b, want 0", sel_err);
        end
        tick();
        checks++;
        if (y !== 4'd1 || y_valid !== 1'b1) begin
            failures++;
            $display("FAIL invalid_recover: y=%0d v=%0b, want 1 1", y, y_valid);
        end
    endtask

    task automatic test_scan();
        logic [3:0] exp_y;
        logic       exp_adv;
        int         seg;
        mode = 1'b1;
        for (int n = 1; n <= 29; n++) begin
            if (n == 14) ch_en = 3'b101;
            tick();
            if (n <= 5) exp_y = 4'd1;
            else begin
                seg = (n - 6) / 4;
                case (seg)
                    0:       exp_y = 4'd2;
                    1:       exp_y = 4'd3;
                    2:       exp_y = 4'd1;
                    3:       exp_y = 4'd3;
                    4:       exp_y = 4'd1;
                    default: exp_y = 4'd3;
                endcase
            end
            exp_adv = (n >= 5) && ((n - 5) % 4 == 0);
            checks++;
            if (y !== exp_y || adv !== exp_adv || y_valid !== 1'b1) begin
                failures++;
                $display("FAIL scan n=%0d: y=%0d adv=%0b v=%0b, want %0d %0b 1", n, y, adv, y_valid, exp_y, exp_adv);
            end
        end
    endtask

    task automatic test_scan_none();
        bit seen;
        ch_en = 3'b000;
        for (int n = 0; n < 8; n++) begin
            tick();
            checks++;
            if (y !== 4'd0 || y_valid !== 1'b0 || adv !== 1'b0) begin
                failures++;
                $display("FAIL scan_none n=%0d: y=%0d v=%0b adv=%0b, want 0 0 0", n, y, y_valid, adv);
            end
        end
        ch_en = 3'b010;
        seen = 1'b0;
        for (int n = 0; n < 12 && !seen; n++) begin
            tick();
            if (y === 4'd2) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL scan_single_wait: y=%0d, want 2 within 12 cycles", y);
        end
        for (int n = 0; n < 8; n++) begin
            tick();
            checks++;
            if (y !== 4'd2 || y_valid !== 1'b1 || cur_ch !== 2'd1) begin
                failures++;
                $display("FAIL scan_single n=%0d: y=%0d v=%0b ch=%0d, want 2 1 1", n, y, y_valid, cur_ch);
            end
        end
    endtask

    task automatic test_manual_disable();
        mode = 1'b0; sel = 2'd0; load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (cur_ch !== 2'd1) begin
            failures++;
            $display("FAIL mode_load_same_cycle: ch=%0d, want 1", cur_ch);
        end
        ch_en = 3'b111; sel = 2'd2; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        checks++;
        if (cur_ch !== 2'd2 || y !== 4'd3) begin
            failures++;
            $display("FAIL disable_setup: ch=%0d y=%0d, want 2 3", cur_ch, y);
        end
        ch_en = 3'b011;
        tick();
        checks++;
        if (y !== 4'd0 || y_valid !== 1'b0 || sel_err !== 1'b0) begin
            failures++;
            $display("FAIL disable_y: y=%0d v=%0b err=%0b, want 0 0 0", y, y_valid, sel_err);
        end
        ch_en = 3'b111;
        tick();
        checks++;
        if (y !== 4'd3 || y_valid !== 1'b1) begin
            failures++;
            $display("FAIL reenable_y: y=%0d v=%0b, want 3 1", y, y_valid);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic exp_adv;
        sel = 2'd3; load = 1'b1;
        tick();
        load = 1'b0;
        mode = 1'b1;
        tick();
        sel = 2'd0; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        checks++;
        if (cur_ch !== 2'd2 || y !== 4'd3 || y_valid !== 1'b1 || sel_err !== 1'b1) begin
            failures++;
            $display("FAIL scan_hold: ch=%0d y=%0d v=%0b err=%0b, want 2 3 1 1", cur_ch, y, y_valid, sel_err);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (y !== 4'd0 || y_valid !== 1'b0 || cur_ch !== 2'd0 || sel_err !== 1'b0 || adv !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_scan: y=%0d v=%0b ch=%0d err=%0b adv=%0b, want 0 0 0 0 0", y, y_valid, cur_ch, sel_err, adv);
        end
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp_adv = (k == 5);
            checks++;
            if (adv !== exp_adv) begin
                failures++;
                $display("FAIL post_reset_adv k=%0d: adv=%0b, want %0b", k, adv, exp_adv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_invalid();
        test_scan();
        test_scan_none();
        test_manual_disable();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
